// File: rtl/diff_tdm_dec.sv
// diff_tdm_dec: frame-aligning decoder for a two-channel
// differential-Manchester TDM line (A_h1,B_h1,A_h2,B_h2).
//
// Ports:
//   clk  line clock, one half-cell sample per rising edge
//   rst  synchronous active-high reset
//   m    TDM line input
//   a,b  decoded channel bits, held between frames
//   dv   one-cycle strobe, new a/b pair
//   lock frame alignment established
//   err  one-cycle strobe, code violation while locked
module diff_tdm_dec #(
  parameter int LOCK_FRAMES = 8,
  parameter int LOSS_FRAMES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic m,
  output logic a,
  output logic b,
  output logic dv,
  output logic lock,
  output logic err
);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);
  localparam logic [7:0] LOSS_N = 8'(LOSS_FRAMES);

  state_t     state;
  state_t     state_nx;
  logic [1:0] ph;
  logic [1:0] ph_nx;
  logic       slip;
  logic       slip_nx;
  logic [7:0] good_cnt;
  logic [7:0] good_nx;
  logic [7:0] bad_cnt;
  logic [7:0] bad_nx;

  logic       a_h1;
  logic       b_h1;
  logic       a_h2;
  logic       prev_a;
  logic       prev_b;

  logic       frame_end;
  logic       viol;
  logic       bit_a;
  logic       bit_b;
  logic       dv_nx;
  logic       err_nx;

  // Result stage between the frame check and the outputs.
  logic       dv_p;
  logic       err_p;
  logic       a_p;
  logic       b_p;

  // The slip cycle repeats ph=3 without checking a frame;
  // its sample is simply dropped.
  assign frame_end = (ph == 2'd3) && !slip;

  // B_h2 is the live sample on the ph=3 edge.
  assign viol  = (a_h1 == a_h2) || (b_h1 == m);
  assign bit_a = (prev_a == a_h1);
  assign bit_b = (prev_b == b_h1);

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    bad_nx   = bad_cnt;
    slip_nx  = 1'b0;
    ph_nx    = ph + 2'd1;
    dv_nx    = 1'b0;
    err_nx   = 1'b0;
    if (frame_end) begin
      unique case (state)
        HUNT: begin
          if (viol) begin
            good_nx = 8'd0;
            slip_nx = 1'b1;
          end else if (good_cnt + 8'd1 == LOCK_N) begin
            state_nx = LOCKED;
            good_nx  = 8'd0;
          end else begin
            good_nx = good_cnt + 8'd1;
          end
        end
        LOCKED: begin
          if (!viol) begin
            dv_nx  = 1'b1;
            bad_nx = 8'd0;
          end else begin
            err_nx = 1'b1;
            if (bad_cnt + 8'd1 == LOSS_N) begin
              state_nx = HUNT;
              bad_nx   = 8'd0;
              slip_nx  = 1'b1;
            end else begin
              bad_nx = bad_cnt + 8'd1;
            end
          end
        end
        default: begin
          state_nx = HUNT;
        end
      endcase
      // Hold ph at 3 so the next frame starts one clock later.
      if (slip_nx) begin
        ph_nx = 2'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      ph       <= 2'd0;
      slip     <= 1'b0;
      good_cnt <= 8'd0;
      bad_cnt  <= 8'd0;
      a_h1     <= 1'b0;
      b_h1     <= 1'b0;
      a_h2     <= 1'b0;
      prev_a   <= 1'b0;
      prev_b   <= 1'b0;
      dv_p     <= 1'b0;
      err_p    <= 1'b0;
      a_p      <= 1'b0;
      b_p      <= 1'b0;
      a        <= 1'b0;
      b        <= 1'b0;
      dv       <= 1'b0;
      err      <= 1'b0;
      lock     <= 1'b0;
    end else begin
      state    <= state_nx;
      ph       <= ph_nx;
      slip     <= slip_nx;
      good_cnt <= good_nx;
      bad_cnt  <= bad_nx;

      unique case (ph)
        2'd0:    a_h1 <= m;
        2'd1:    b_h1 <= m;
        2'd2:    a_h2 <= m;
        default: ;
      endcase

      if (frame_end) begin
        prev_a <= a_h2;
        prev_b <= m;
        a_p    <= bit_a;
        b_p    <= bit_b;
      end
      dv_p  <= dv_nx;
      err_p <= err_nx;

      dv  <= dv_p;
      err <= err_p;
      if (dv_p) begin
        a <= a_p;
        b <= b_p;
      end
      lock <= (state == LOCKED);
    end
  end

endmodule

// File: tb/tb_diff_tdm_dec.sv
// tb_diff_tdm_dec: randomized bench for diff_tdm_dec
// against a frame-position reference model.
module tb_diff_tdm_dec;

  localparam int LOCKF = 8;
  localparam int LOSSF = 4;
  localparam int NMAX  = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m   = 1'b0;
  logic a, b, dv, lock, err;

  int checks = 0;
  int passed = 0;

  int   n;
  logic s     [NMAX];
  logic ba    [256];
  logic bb    [256];
  logic e_a   [NMAX];
  logic e_b   [NMAX];
  logic e_dv  [NMAX];
  logic e_err [NMAX];
  logic e_lock[NMAX];
  logic ev_a  [NMAX];
  logic ev_b  [NMAX];
  logic l_set [NMAX];
  logic l_val [NMAX];
  logic o_a   [NMAX];
  logic o_b   [NMAX];
  logic o_dv  [NMAX];
  logic o_err [NMAX];
  logic o_lock[NMAX];

  diff_tdm_dec #(
    .LOCK_FRAMES(LOCKF),
    .LOSS_FRAMES(LOSSF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .m   (m),
    .a   (a),
    .b   (b),
    .dv  (dv),
    .lock(lock),
    .err (err)
  );

  always #5 clk = ~clk;

  // Encode nf frames; mode 0 = fixed pattern, 1 = random.
  // Frames c_lo..c_hi get A_h2 forced equal to A_h1.
  task automatic gen_stream(input int nf, input int dly,
                            input int mode, input int c_lo,
                            input int c_hi, input int pad);
    logic la, lb, ah1, ah2, bh1, bh2;
    la = 1'b0;
    lb = 1'b0;
    n  = 0;
    for (int i = 0; i < dly; i++) begin
      s[n] = 1'b0;
      n++;
    end
    for (int f = 0; f < nf; f++) begin
      if (mode == 0) begin
        ba[f] = (f % 2 == 0);
        bb[f] = (f % 4 == 1) || (f % 4 == 2);
      end else begin
        ba[f] = 1'($urandom_range(0, 1));
        bb[f] = 1'($urandom_range(0, 1));
      end
      ah1 = ba[f] ? la : ~la;
      bh1 = bb[f] ? lb : ~lb;
      ah2 = ~ah1;
      bh2 = ~bh1;
      la = ah2;
      lb = bh2;
      s[n]   = ah1;
      s[n+1] = bh1;
      s[n+2] = (f >= c_lo && f <= c_hi) ? ah1 : ah2;
      s[n+3] = bh2;
      n += 4;
    end
    for (int i = 0; i < pad; i++) begin
      s[n] = 1'b0;
      n++;
    end
  endtask

  // Walk the sample array frame by frame from a start position;
  // a slip moves the next frame start 5 samples on instead of 4.
  task automatic build_model();
    int   pos, good, bad, o;
    bit   locked, slp, vio;
    logic pa, pb, xa, xb, ca, cb, cl;
    for (int k = 0; k < n; k++) begin
      e_dv[k]  = 1'b0;
      e_err[k] = 1'b0;
      l_set[k] = 1'b0;
      l_val[k] = 1'b0;
      ev_a[k]  = 1'b0;
      ev_b[k]  = 1'b0;
    end
    pos    = 0;
    good   = 0;
    bad    = 0;
    locked = 1'b0;
    pa     = 1'b0;
    pb     = 1'b0;
    while (pos + 4 < n) begin
      vio = (s[pos] == s[pos+2]) || (s[pos+1] == s[pos+3]);
      xa  = (pa == s[pos]);
      xb  = (pb == s[pos+1]);
      pa  = s[pos+2];
      pb  = s[pos+3];
      slp = 1'b0;
      o   = pos + 4;
      if (!locked) begin
        if (vio) begin
          good = 0;
          slp  = 1'b1;
        end else begin
          good++;
          if (good == LOCKF) begin
            locked = 1'b1;
            good   = 0;
          end
        end
      end else begin
        if (!vio) begin
          e_dv[o] = 1'b1;
          ev_a[o] = xa;
          ev_b[o] = xb;
          bad     = 0;
        end else begin
          e_err[o] = 1'b1;
          bad++;
          if (bad == LOSSF) begin
            locked = 1'b0;
            bad    = 0;
            slp    = 1'b1;
          end
        end
      end
      l_set[o] = 1'b1;
      l_val[o] = locked;
      pos += slp ? 5 : 4;
    end
    ca = 1'b0;
    cb = 1'b0;
    cl = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (e_dv[k]) begin
        ca = ev_a[k];
        cb = ev_b[k];
      end
      if (l_set[k]) cl = l_val[k];
      e_a[k]    = ca;
      e_b[k]    = cb;
      e_lock[k] = cl;
    end
  endtask

  task automatic apply_reset(input int cyc, input string nm);
    rst = 1'b1;
    for (int i = 0; i < cyc; i++) begin
      m = ~m;
      @(posedge clk);
      #1;
      checks++;
      if ({a, b, dv, lock, err} !== 5'b0) begin
        $display("FAIL %s reset edge %0d: a,b,dv,lock,err=%b want 00000",
                 nm, i, {a, b, dv, lock, err});
      end else begin
        passed++;
      end
    end
    rst = 1'b0;
  endtask

  task automatic run_stream(input string nm);
    for (int k = 0; k < n; k++) begin
      m = s[k];
      @(posedge clk);
      #1;
      o_a[k]    = a;
      o_b[k]    = b;
      o_dv[k]   = dv;
      o_err[k]  = err;
      o_lock[k] = lock;
      checks++;
      if ({a, b, dv, lock, err} !==
          {e_a[k], e_b[k], e_dv[k], e_lock[k], e_err[k]}) begin
        $display("FAIL %s edge %0d: a,b,dv,lock,err=%b want %b",
                 nm, k, {a, b, dv, lock, err},
                 {e_a[k], e_b[k], e_dv[k], e_lock[k], e_err[k]});
      end else begin
        passed++;
      end
    end
  endtask

  function automatic int first_lock();
    for (int k = 0; k < n; k++) begin
      if (o_lock[k]) return k;
    end
    return -1;
  endfunction

  task automatic test_reset();
    int early;
    apply_reset(3, "reset");
    gen_stream(9, 0, 1, -1, -1, 4);
    build_model();
    run_stream("reset_run");
    early = 0;
    for (int k = 0; k < 4 * LOCKF; k++) begin
      if (o_lock[k]) early++;
    end
    checks++;
    if (early !== 0) begin
      $display("FAIL reset_hold: lock high %0d cycles, want 0", early);
    end else begin
      passed++;
    end
  endtask

  task automatic test_aligned_lock();
    int fl, cnt, f;
    apply_reset(1, "aligned");
    gen_stream(20, 0, 0, -1, -1, 4);
    build_model();
    run_stream("aligned");
    fl = first_lock();
    checks++;
    if (fl !== 32) begin
      $display("FAIL aligned_lock_edge: got %0d want 32", fl);
    end else begin
      passed++;
    end
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      if (o_dv[k]) begin
        cnt++;
        f = k / 4 - 1;
        checks++;
        if (k % 4 != 0 || f < 0) begin
          $display("FAIL aligned_dv_slot: dv at %0d want multiple of 4",
                   k);
        end else if ({o_a[k], o_b[k]} !== {ba[f], bb[f]}) begin
          $display("FAIL aligned_data f%0d: ab=%b%b want %b%b",
                   f, o_a[k], o_b[k], ba[f], bb[f]);
        end else begin
          passed++;
        end
      end
    end
    checks++;
    if (cnt !== 12) begin
      $display("FAIL aligned_dv_count: got %0d want 12", cnt);
    end else begin
      passed++;
    end
  endtask

  task automatic test_misaligned();
    int fl, pre, f;
    apply_reset(1, "misaligned");
    gen_stream(30, 2, 0, -1, -1, 4);
    build_model();
    run_stream("misaligned");
    fl = first_lock();
    checks++;
    if (fl < 0 || fl + 1 > 4 * (3 + LOCKF) + 3) begin
      $display("FAIL misaligned_lock_time: got %0d want <= %0d",
               fl + 1, 4 * (3 + LOCKF) + 3);
    end else begin
      passed++;
    end
    pre = 0;
    for (int k = 0; k < n; k++) begin
      if (o_dv[k] && (fl < 0 || k < fl)) pre++;
    end
    checks++;
    if (pre !== 0) begin
      $display("FAIL misaligned_dv_before_lock: got %0d want 0", pre);
    end else begin
      passed++;
    end
    for (int k = 6; k < n; k++) begin
      if (o_dv[k]) begin
        f = (k - 6) / 4;
        checks++;
        if ((k - 6) % 4 != 0 ||
            {o_a[k], o_b[k]} !== {ba[f], bb[f]}) begin
          $display("FAIL misaligned_data edge %0d: ab=%b%b want %b%b",
                   k, o_a[k], o_b[k], ba[f], bb[f]);
        end else begin
          passed++;
        end
      end
    end
  endtask

  task automatic test_single_violation();
    int errs, drop;
    apply_reset(1, "single");
    gen_stream(24, 0, 1, 12, 12, 4);
    build_model();
    run_stream("single");
    errs = 0;
    drop = 0;
    for (int k = 0; k < n; k++) begin
      if (o_err[k]) errs++;
      if (k >= 32 && !o_lock[k]) drop++;
    end
    checks++;
    if (errs !== 1 || o_err[52] !== 1'b1 || o_dv[52] !== 1'b0) begin
      $display("FAIL single_err: errs=%0d err52=%b dv52=%b want 1 1 0",
               errs, o_err[52], o_dv[52]);
    end else begin
      passed++;
    end
    checks++;
    if (drop !== 0) begin
      $display("FAIL single_lock_kept: lock low %0d cycles want 0", drop);
    end else begin
      passed++;
    end
    checks++;
    if (o_dv[56] !== 1'b1 || o_b[56] !== bb[13]) begin
      $display("FAIL single_next: dv=%b b=%b want 1 %b",
               o_dv[56], o_b[56], bb[13]);
    end else begin
      passed++;
    end
  endtask

  task automatic test_loss_of_lock();
    int errs;
    apply_reset(1, "loss");
    gen_stream(60, 0, 1, 12, 15, 4);
    build_model();
    run_stream("loss");
    errs = 0;
    for (int k = 0; k < n; k++) begin
      if (o_err[k]) errs++;
    end
    checks++;
    if (errs !== 4) begin
      $display("FAIL loss_err_count: got %0d want 4", errs);
    end else begin
      passed++;
    end
    checks++;
    if (o_lock[63] !== 1'b1 || o_lock[64] !== 1'b0) begin
      $display("FAIL loss_lock_drop: lock63=%b lock64=%b want 1 0",
               o_lock[63], o_lock[64]);
    end else begin
      passed++;
    end
    checks++;
    if (o_lock[n-1] !== 1'b1) begin
      $display("FAIL loss_relock: lock=%b want 1", o_lock[n-1]);
    end else begin
      passed++;
    end
  endtask

  task automatic test_reset_mid_lock();
    int fl;
    apply_reset(1, "midlock");
    gen_stream(14, 0, 1, -1, -1, 0);
    build_model();
    run_stream("midlock_pre");
    checks++;
    if (o_lock[n-1] !== 1'b1) begin
      $display("FAIL midlock_locked: lock=%b want 1", o_lock[n-1]);
    end else begin
      passed++;
    end
    apply_reset(1, "midlock");
    gen_stream(12, 0, 1, -1, -1, 4);
    build_model();
    run_stream("midlock_post");
    fl = first_lock();
    checks++;
    if (fl !== 32) begin
      $display("FAIL midlock_relock: got %0d want 32", fl);
    end else begin
      passed++;
    end
  endtask

  task automatic test_back_to_back();
    int off;
    for (int it = 0; it < 3; it++) begin
      off = $urandom_range(0, 3);
      apply_reset(1, "b2b");
      gen_stream(40, off, 1, -1, -1, 4);
      build_model();
      run_stream("b2b");
      checks++;
      if (o_lock[n-1] !== 1'b1) begin
        $display("FAIL b2b_lock off=%0d: lock=%b want 1",
                 off, o_lock[n-1]);
      end else begin
        passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_aligned_lock();
    test_misaligned();
    test_single_violation();
    test_loss_of_lock();
    test_reset_mid_lock();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
